// File: rtl/elevator_call_scheduler.sv
// Call-button front end for the elevator controller: synchronises and latches
// floor calls, picks the next target with a SCAN sweep and times the door dwell.
module elevator_call_scheduler #(
  parameter int unsigned NUM_FLOORS  = 8,
  parameter logic [31:0] DWELL_COUNT = 32'd100000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NUM_FLOORS-1:0] call_btn,
  input  logic [3:0]            current_floor,
  input  logic                  elevator_idle,
  output logic [3:0]            requested_floor,
  output logic [NUM_FLOORS-1:0] pending,
  output logic                  door_open,
  output logic                  dir_up,
  output logic [1:0]            dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_TRAVEL = 2'd1,
    S_DWELL  = 2'd2
  } state_e;

  localparam logic [3:0]  FLOOR_LIMIT = 4'(NUM_FLOORS);
  localparam logic [31:0] DWELL_LAST  = DWELL_COUNT - 32'd1;

  state_e                  state_q;
  logic [3:0]              requested_floor_q;
  logic                    dir_up_q;
  logic                    door_open_q;
  logic [31:0]             dwell_cnt_q;
  logic [NUM_FLOORS-1:0]   pending_q, pending_d;

  logic [NUM_FLOORS-1:0]   sync1_q, sync2_q, prev_q;
  logic [2:0]              arm_q;
  logic [NUM_FLOORS-1:0]   rise;

  // Edges are only trusted once the synchronizer has refilled after reset,
  // so a button held through reset is not taken as a fresh call.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
      prev_q  <= '0;
      arm_q   <= '0;
    end else begin
      sync1_q <= call_btn;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
      arm_q   <= {arm_q[1:0], 1'b1};
    end
  end

  assign rise = arm_q[2] ? (sync2_q & ~prev_q) : '0;

  logic [NUM_FLOORS-1:0] cur_mask;
  logic                  up_found, dn_found;
  logic [3:0]            up_tgt, dn_tgt;

  always_comb begin
    cur_mask = '0;
    up_found = 1'b0;
    up_tgt   = '0;
    dn_found = 1'b0;
    dn_tgt   = '0;
    for (int i = 0; i < NUM_FLOORS; i++) begin
      if (4'(i) == current_floor) cur_mask[i] = 1'b1;
    end
    // Descending scan leaves the lowest qualifying floor above the car.
    for (int i = NUM_FLOORS - 1; i >= 0; i--) begin
      if (pending_q[i] && (4'(i) > current_floor)) begin
        up_found = 1'b1;
        up_tgt   = 4'(i);
      end
    end
    for (int i = 0; i < NUM_FLOORS; i++) begin
      if (pending_q[i] && (4'(i) < current_floor)) begin
        dn_found = 1'b1;
        dn_tgt   = 4'(i);
      end
    end
  end

  logic       tgt_valid;
  logic [3:0] tgt_floor;
  logic       tgt_dir;

  always_comb begin
    tgt_floor = requested_floor_q;
    tgt_dir   = dir_up_q;
    tgt_valid = up_found | dn_found;
    if (dir_up_q) begin
      if (up_found) begin
        tgt_floor = up_tgt;
        tgt_dir   = 1'b1;
      end else if (dn_found) begin
        tgt_floor = dn_tgt;
        tgt_dir   = 1'b0;
      end
    end else begin
      if (dn_found) begin
        tgt_floor = dn_tgt;
        tgt_dir   = 1'b0;
      end else if (up_found) begin
        tgt_floor = up_tgt;
        tgt_dir   = 1'b1;
      end
    end
  end

  logic                  in_range;
  logic                  cur_pend;
  logic                  cur_rise;
  logic                  arrived;
  logic                  dwell_last;
  logic                  dwell_done;
  logic [NUM_FLOORS-1:0] clr_mask;

  assign in_range   = current_floor < FLOOR_LIMIT;
  assign cur_pend   = |(pending_q & cur_mask);
  assign cur_rise   = |(rise & cur_mask);
  assign arrived    = elevator_idle && (current_floor == requested_floor_q);
  assign dwell_last = dwell_cnt_q == DWELL_LAST;
  // A re-press of the served floor on the last dwell cycle keeps the call alive.
  assign dwell_done = (state_q == S_DWELL) && dwell_last && !cur_rise;
  assign clr_mask   = dwell_done ? cur_mask : '0;
  assign pending_d  = (pending_q & ~clr_mask) | rise;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pending_q <= '0;
    else        pending_q <= pending_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q           <= S_IDLE;
      requested_floor_q <= '0;
      dir_up_q          <= 1'b1;
      door_open_q       <= 1'b0;
      dwell_cnt_q       <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (in_range) begin
            requested_floor_q <= current_floor;
            if (cur_pend && elevator_idle) begin
              state_q     <= S_DWELL;
              door_open_q <= 1'b1;
              dwell_cnt_q <= '0;
            end else if (tgt_valid) begin
              requested_floor_q <= tgt_floor;
              dir_up_q          <= tgt_dir;
              state_q           <= S_TRAVEL;
            end
          end
        end
        S_TRAVEL: begin
          if (arrived) begin
            state_q     <= S_DWELL;
            door_open_q <= 1'b1;
            dwell_cnt_q <= '0;
          end else if (pending_q == '0) begin
            state_q <= S_IDLE;
          end else if (in_range && tgt_valid) begin
            requested_floor_q <= tgt_floor;
            dir_up_q          <= tgt_dir;
          end
        end
        S_DWELL: begin
          door_open_q <= 1'b1;
          if (in_range) requested_floor_q <= current_floor;
          if (cur_rise) begin
            dwell_cnt_q <= '0;
          end else if (dwell_last) begin
            dwell_cnt_q <= '0;
            door_open_q <= 1'b0;
            state_q     <= S_IDLE;
          end else begin
            dwell_cnt_q <= dwell_cnt_q + 32'd1;
          end
        end
        default: begin
          state_q     <= S_IDLE;
          door_open_q <= 1'b0;
          dwell_cnt_q <= '0;
        end
      endcase
    end
  end

  assign requested_floor = requested_floor_q;
  assign pending         = pending_q;
  assign door_open       = door_open_q;
  assign dir_up          = dir_up_q;
  assign dbg_state       = state_q;

endmodule

// File: tb/tb_elevator_call_scheduler.sv
// Bench for elevator_call_scheduler: table of target-selection vectors with a
// frozen car, then hand sequences driving a car that moves one floor per 3 cycles.
module tb_elevator_call_scheduler;

  localparam int          NF = 8;
  localparam logic [31:0] DW = 32'd4;
  localparam logic [1:0]  ST_IDLE   = 2'd0;
  localparam logic [1:0]  ST_TRAVEL = 2'd1;
  localparam logic [1:0]  ST_DWELL  = 2'd2;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [NF-1:0] call_btn;
  logic [3:0]    current_floor;
  logic          elevator_idle;
  logic [3:0]    requested_floor;
  logic [NF-1:0] pending;
  logic          door_open;
  logic          dir_up;
  logic [1:0]    dbg_state;

  elevator_call_scheduler #(.NUM_FLOORS(NF), .DWELL_COUNT(DW)) dut (
    .clk(clk), .rst_n(rst_n), .call_btn(call_btn),
    .current_floor(current_floor), .elevator_idle(elevator_idle),
    .requested_floor(requested_floor), .pending(pending),
    .door_open(door_open), .dir_up(dir_up), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // ---------------- car model ----------------
  logic       car_auto  = 1'b1;
  logic       car_hold  = 1'b0;
  logic [3:0] car_start = 4'd0;
  logic [3:0] car_floor = 4'd0;
  logic       car_idle  = 1'b1;
  logic [3:0] man_floor = 4'd0;
  logic       man_idle  = 1'b0;
  int         mv_cnt    = 0;

  always @(negedge clk) begin
    if (!rst_n) begin
      car_floor = car_start;
      mv_cnt    = 0;
      car_idle  = 1'b1;
    end else if (!car_hold) begin
      if (car_floor != requested_floor) begin
        mv_cnt++;
        if (mv_cnt == 3) begin
          mv_cnt    = 0;
          car_floor = (car_floor < requested_floor) ? car_floor + 4'd1 : car_floor - 4'd1;
        end
      end else begin
        mv_cnt = 0;
      end
      car_idle = (car_floor == requested_floor);
    end
  end

  assign current_floor = car_auto ? car_floor : man_floor;
  assign elevator_idle = car_auto ? car_idle  : man_idle;

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic do_reset(input logic [3:0] start);
    car_start = start;
    call_btn  = '0;
    car_hold  = 1'b0;
    rst_n     = 1'b0;
    repeat (2) step();
    rst_n = 1'b1;
    repeat (3) step();
  endtask

  task automatic wait_door(input string name, input int budget);
    int k;
    k = 0;
    while (door_open !== 1'b1 && k < budget) begin
      step();
      k++;
    end
    chk(name, 32'(door_open), 32'd1);
  endtask

  task automatic wait_floor(input string name, input logic [3:0] fl, input int budget);
    int k;
    k = 0;
    while (current_floor !== fl && k < budget) begin
      step();
      k++;
    end
    chk(name, 32'(current_floor), 32'(fl));
  endtask

  task automatic count_door(output int n);
    n = 0;
    while (door_open === 1'b1 && n < 100) begin
      n++;
      step();
    end
  endtask

  // ---------------- target-selection vectors ----------------
  typedef struct {
    logic [3:0]    cur0;
    logic [NF-1:0] mask;
    logic [3:0]    req0;
    logic          dir0;
    logic [1:0]    st0;
    logic [3:0]    cur1;
    logic [3:0]    req1;
    logic          dir1;
    logic [1:0]    st1;
  } vec_t;

  vec_t vecs[8];

  initial begin
    int n;
    vecs[0] = '{4'd0,  8'h20, 4'd5, 1'b1, ST_TRAVEL, 4'd7, 4'd5, 1'b0, ST_TRAVEL};
    vecs[1] = '{4'd4,  8'h44, 4'd6, 1'b1, ST_TRAVEL, 4'd6, 4'd2, 1'b0, ST_TRAVEL};
    vecs[2] = '{4'd5,  8'h09, 4'd3, 1'b0, ST_TRAVEL, 4'd2, 4'd0, 1'b0, ST_TRAVEL};
    vecs[3] = '{4'd3,  8'h08, 4'd3, 1'b1, ST_IDLE,   4'd1, 4'd3, 1'b1, ST_TRAVEL};
    vecs[4] = '{4'd2,  8'h8A, 4'd3, 1'b1, ST_TRAVEL, 4'd0, 4'd1, 1'b1, ST_TRAVEL};
    vecs[5] = '{4'd12, 8'h10, 4'd0, 1'b1, ST_IDLE,   4'd6, 4'd4, 1'b0, ST_TRAVEL};
    vecs[6] = '{4'd6,  8'h41, 4'd0, 1'b0, ST_TRAVEL, 4'd9, 4'd0, 1'b0, ST_TRAVEL};
    vecs[7] = '{4'd0,  8'h81, 4'd7, 1'b1, ST_TRAVEL, 4'd7, 4'd0, 1'b0, ST_TRAVEL};

    rst_n    = 1'b0;
    call_btn = '0;

    // Table: car frozen and never idle, so only target selection is exercised.
    car_auto = 1'b0;
    man_idle = 1'b0;
    for (int v = 0; v < 8; v++) begin
      man_floor = vecs[v].cur0;
      do_reset(4'd0);
      call_btn = vecs[v].mask;
      repeat (2) step();
      chk($sformatf("v%0d_lat2", v), 32'(pending), 32'd0);
      step();
      chk($sformatf("v%0d_pend", v), 32'(pending), 32'(vecs[v].mask));
      call_btn = '0;
      step();
      chk($sformatf("v%0d_req0", v), 32'(requested_floor), 32'(vecs[v].req0));
      chk($sformatf("v%0d_dir0", v), 32'(dir_up), 32'(vecs[v].dir0));
      chk($sformatf("v%0d_st0", v), 32'(dbg_state), 32'(vecs[v].st0));
      man_floor = vecs[v].cur1;
      step();
      chk($sformatf("v%0d_req1", v), 32'(requested_floor), 32'(vecs[v].req1));
      chk($sformatf("v%0d_dir1", v), 32'(dir_up), 32'(vecs[v].dir1));
      chk($sformatf("v%0d_st1", v), 32'(dbg_state), 32'(vecs[v].st1));
    end
    car_auto = 1'b1;

    // A: reset values, single call to floor 5 from floor 0.
    do_reset(4'd0);
    chk("a_rst_req", 32'(requested_floor), 32'd0);
    chk("a_rst_pend", 32'(pending), 32'd0);
    chk("a_rst_door", 32'(door_open), 32'd0);
    chk("a_rst_dir", 32'(dir_up), 32'd1);
    chk("a_rst_st", 32'(dbg_state), 32'(ST_IDLE));
    call_btn = 8'h20;
    repeat (2) step();
    chk("a_lat2", 32'(pending), 32'd0);
    step();
    chk("a_pend", 32'(pending), 32'h20);
    call_btn = '0;
    step();
    chk("a_req", 32'(requested_floor), 32'd5);
    chk("a_st_travel", 32'(dbg_state), 32'(ST_TRAVEL));
    wait_door("a_door_rise", 60);
    chk("a_floor", 32'(current_floor), 32'd5);
    count_door(n);
    chk("a_dwell_len", 32'(n), 32'd4);
    chk("a_pend_clr", 32'(pending), 32'd0);
    chk("a_st_idle", 32'(dbg_state), 32'(ST_IDLE));
    chk("a_req_hold", 32'(requested_floor), 32'd5);

    // B: retarget to a closer call in the sweep direction.
    do_reset(4'd1);
    call_btn = 8'h40;
    repeat (3) step();
    call_btn = '0;
    step();
    chk("b_req6", 32'(requested_floor), 32'd6);
    wait_floor("b_reach2", 4'd2, 30);
    car_hold = 1'b1;
    chk("b_dir", 32'(dir_up), 32'd1);
    call_btn = 8'h08;
    repeat (3) step();
    chk("b_pend", 32'(pending), 32'h48);
    step();
    chk("b_retarget", 32'(requested_floor), 32'd3);
    car_hold = 1'b0;
    call_btn = '0;
    wait_door("b_door3", 40);
    chk("b_floor3", 32'(current_floor), 32'd3);
    count_door(n);
    chk("b_dwell3", 32'(n), 32'd4);
    chk("b_pend6", 32'(pending), 32'h40);
    step();
    chk("b_req_next", 32'(requested_floor), 32'd6);
    chk("b_dir_next", 32'(dir_up), 32'd1);
    wait_door("b_door6", 40);
    chk("b_floor6", 32'(current_floor), 32'd6);
    count_door(n);
    chk("b_pend_empty", 32'(pending), 32'd0);

    // C: up sweep from 4 serves 6 before reversing to 2.
    do_reset(4'd4);
    call_btn = 8'h44;
    repeat (4) step();
    call_btn = '0;
    chk("c_req6", 32'(requested_floor), 32'd6);
    chk("c_dir_up", 32'(dir_up), 32'd1);
    wait_door("c_door6", 40);
    chk("c_floor6", 32'(current_floor), 32'd6);
    count_door(n);
    chk("c_dwell6", 32'(n), 32'd4);
    chk("c_pend2", 32'(pending), 32'h04);
    step();
    chk("c_req2", 32'(requested_floor), 32'd2);
    chk("c_dir_dn", 32'(dir_up), 32'd0);
    wait_door("c_door2", 60);
    chk("c_floor2", 32'(current_floor), 32'd2);
    count_door(n);
    chk("c_pend_empty", 32'(pending), 32'd0);

    // D: call at the car's own floor while idle opens the door directly.
    do_reset(4'd0);
    call_btn = 8'h01;
    repeat (3) step();
    chk("d_pend", 32'(pending), 32'h01);
    chk("d_st_idle", 32'(dbg_state), 32'(ST_IDLE));
    call_btn = '0;
    step();
    chk("d_door", 32'(door_open), 32'd1);
    chk("d_st_dwell", 32'(dbg_state), 32'(ST_DWELL));
    chk("d_req0", 32'(requested_floor), 32'd0);
    count_door(n);
    chk("d_dwell_len", 32'(n), 32'd4);
    chk("d_pend_clr", 32'(pending), 32'd0);

    // E: re-press on the last dwell cycle restarts the dwell.
    do_reset(4'd3);
    call_btn = 8'h08;
    repeat (3) step();
    chk("e_pend", 32'(pending), 32'h08);
    call_btn = '0;
    step();
    chk("e_door_c0", 32'(door_open), 32'd1);
    step();
    chk("e_door_c1", 32'(door_open), 32'd1);
    call_btn = 8'h08;
    repeat (3) step();
    chk("e_door_last", 32'(door_open), 32'd1);
    chk("e_pend_kept", 32'(pending), 32'h08);
    call_btn = '0;
    count_door(n);
    chk("e_restart_len", 32'(n), 32'd4);
    chk("e_pend_clr", 32'(pending), 32'd0);
    chk("e_st_idle", 32'(dbg_state), 32'(ST_IDLE));

    // F: asynchronous reset mid-travel with buttons held through it.
    do_reset(4'd3);
    call_btn = 8'h81;
    repeat (4) step();
    chk("f_pend", 32'(pending), 32'h81);
    chk("f_st_travel", 32'(dbg_state), 32'(ST_TRAVEL));
    chk("f_req7", 32'(requested_floor), 32'd7);
    step();
    #2;
    rst_n = 1'b0;
    #1;
    chk("f_async_req", 32'(requested_floor), 32'd0);
    chk("f_async_pend", 32'(pending), 32'd0);
    chk("f_async_door", 32'(door_open), 32'd0);
    chk("f_async_dir", 32'(dir_up), 32'd1);
    chk("f_async_st", 32'(dbg_state), 32'(ST_IDLE));
    repeat (2) step();
    rst_n = 1'b1;
    repeat (6) step();
    chk("f_held_no_call", 32'(pending), 32'd0);
    chk("f_held_st", 32'(dbg_state), 32'(ST_IDLE));
    call_btn = 8'h00;
    repeat (3) step();
    call_btn = 8'h02;
    repeat (3) step();
    chk("f_new_call", 32'(pending), 32'h02);
    call_btn = '0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not reach its summary, %0d checks so far", n_checks);
    $fatal(1, "watchdog expired");
  end

endmodule
